// File: rtl/seg_pkg.sv
// seg_pkg: shared state encoding and segment bit positions for the seven-segment path
package seg_pkg;
  localparam logic [1:0] IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, LATCH = 2'd3;
  localparam int SEG_W = 8;
  localparam int SEG_A = 0, SEG_B = 1, SEG_C = 2, SEG_D = 3, SEG_E = 4, SEG_F = 5, SEG_G = 6, SEG_DP = 7;
endpackage

// File: rtl/seg_sr_tick.sv
// seg_sr_tick: serial-clock divider, pulses tick_o on the last of every DIV cycles
module seg_sr_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(DIV - 1);
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/seg_shift_out.sv
// seg_shift_out: serialises a segment pattern MSB first into an external 595-style shift register
module seg_shift_out
  import seg_pkg::*;
#(
  parameter int WIDTH       = SEG_W,
  parameter int DIV         = 4,
  parameter int INVERT      = 0,
  parameter int REFRESH_CYC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] seg_in,
  input  logic             seg_valid,
  output logic             seg_ready,
  output logic             sr_data,
  output logic             sr_clk,
  output logic             sr_latch,
  output logic             sr_oe_n,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH);
  localparam int RW = REFRESH_CYC > 1 ? $clog2(REFRESH_CYC) : 1;
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CYC > 0 ? REFRESH_CYC - 1 : 0);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [RW-1:0] ref_q, ref_d;
  logic ready_q, ready_d, data_q, data_d, sck_q, sck_d, lat_q, lat_d, oe_n_q, oe_n_d;
  logic tick, idle, accept, refresh, start;
  seg_sr_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (idle),
    .tick_o (tick)
  );
  always_comb begin
    idle     = state_q == IDLE;
    accept   = idle && seg_valid;
    refresh  = idle && REFRESH_CYC != 0 && ref_q == REF_MAX;
    start    = accept || refresh;
    state_d  = start ? LOW :
               (!tick || idle) ? state_q :
               state_q == LOW ? HIGH :
               state_q == HIGH ? (bit_q == '0 ? LATCH : LOW) : IDLE;
    shadow_d = accept ? seg_in ^ {WIDTH{1'(INVERT)}} : shadow_q;
    bit_d    = start ? BW'(WIDTH - 1) :
               (state_q == HIGH && tick && bit_q != '0) ? bit_q - 1'b1 : bit_q;
    ref_d    = start ? '0 : (idle && REFRESH_CYC != 0 && ref_q != REF_MAX) ? ref_q + 1'b1 : ref_q;
    // outputs are registered from the next state so they change on the edge entering it
    ready_d  = state_d == IDLE;
    sck_d    = state_d == HIGH;
    lat_d    = state_d == LATCH;
    data_d   = state_d == LOW ? shadow_d[bit_d] : data_q;
    oe_n_d   = (state_q == LATCH && tick) ? 1'b0 : oe_n_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      bit_q    <= '0;
      ref_q    <= '0;
      ready_q  <= 1'b1;
      data_q   <= 1'b0;
      sck_q    <= 1'b0;
      lat_q    <= 1'b0;
      oe_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      bit_q    <= bit_d;
      ref_q    <= ref_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      sck_q    <= sck_d;
      lat_q    <= lat_d;
      oe_n_q   <= oe_n_d;
    end
  assign seg_ready = ready_q;
  assign busy      = ~ready_q;
  assign sr_data   = data_q;
  assign sr_clk    = sck_q;
  assign sr_latch  = lat_q;
  assign sr_oe_n   = oe_n_q;
endmodule

// File: tb/tb_seg_shift_out.sv
// tb_seg_shift_out: directed checks of three configurations against an external shift-register model
module tb_seg_shift_out;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] seg_a = '0, seg_b = '0, seg_c = '0;
  logic vld_a = 1'b0, vld_b = 1'b0, vld_c = 1'b0;
  logic rdy_a, dat_a, sck_a, lat_a, oen_a, bsy_a;
  logic rdy_b, dat_b, sck_b, lat_b, oen_b, bsy_b;
  logic rdy_c, dat_c, sck_c, lat_c, oen_c, bsy_c;
  seg_shift_out #(.WIDTH(8), .DIV(1), .INVERT(0), .REFRESH_CYC(0)) u_a (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_a), .seg_valid(vld_a), .seg_ready(rdy_a),
    .sr_data(dat_a), .sr_clk(sck_a), .sr_latch(lat_a), .sr_oe_n(oen_a), .busy(bsy_a));
  seg_shift_out #(.WIDTH(8), .DIV(4), .INVERT(1), .REFRESH_CYC(0)) u_b (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_b), .seg_valid(vld_b), .seg_ready(rdy_b),
    .sr_data(dat_b), .sr_clk(sck_b), .sr_latch(lat_b), .sr_oe_n(oen_b), .busy(bsy_b));
  seg_shift_out #(.WIDTH(8), .DIV(1), .INVERT(0), .REFRESH_CYC(10)) u_c (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_c), .seg_valid(vld_c), .seg_ready(rdy_c),
    .sr_data(dat_c), .sr_clk(sck_c), .sr_latch(lat_c), .sr_oe_n(oen_c), .busy(bsy_c));
  logic [7:0] sh_a = 8'hFF, sh_b = 8'hFF, sh_c = 8'hFF;
  logic [7:0] q_a[$], q_b[$], q_c[$];
  int nrise_a = 0;
  always @(posedge sck_a) begin sh_a <= {sh_a[6:0], dat_a}; nrise_a <= nrise_a + 1; end
  always @(posedge sck_b) sh_b <= {sh_b[6:0], dat_b};
  always @(posedge sck_c) sh_c <= {sh_c[6:0], dat_c};
  always @(posedge lat_a) q_a.push_back(sh_a);
  always @(posedge lat_b) q_b.push_back(sh_b);
  always @(posedge lat_c) q_c.push_back(sh_c);
  int errors = 0;
  int checks = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic rdy(input int id);
    return id == 0 ? rdy_a : id == 1 ? rdy_b : rdy_c;
  endfunction
  task automatic wait_rdy(input int id);
    int n = 0;
    while (!rdy(id) && n < 1000) begin n++; @(negedge clk); end
    chk($sformatf("wait_ready%0d", id), 32'(rdy(id)), 1);
  endtask
  function automatic logic [7:0] last_a(); return q_a.size() > 0 ? q_a[$] : 8'hxx; endfunction
  function automatic logic [7:0] last_c(); return q_c.size() > 0 ? q_c[$] : 8'hxx; endfunction
  initial begin
    int n, run, hi, bad, base;
    logic prev;
    logic [7:0] pats [3];
    pats[0] = 8'h07; pats[1] = 8'h86; pats[2] = 8'h46;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy_a), 1);
    chk("rst_busy", 32'(bsy_a), 0);
    chk("rst_data", 32'(dat_a), 0);
    chk("rst_sclk", 32'(sck_a), 0);
    chk("rst_latch", 32'(lat_a), 0);
    chk("rst_oe_n", 32'(oen_a), 1);
    rst_n = 1'b1;
    // refresh instance: first auto frame after 10 idle cycles carries the reset shadow 0
    n = 0;
    while (rdy_c && n < 50) begin n++; @(negedge clk); end
    chk("ref_first_idle", n, 10);
    wait_rdy(2);
    chk("ref_zero_pattern", 32'(last_c()), 32'h00);
    seg_c = 8'h81; vld_c = 1'b1;
    @(negedge clk);
    vld_c = 1'b0;
    chk("ref_accept_busy", 32'(bsy_c), 1);
    wait_rdy(2);
    chk("ref_81_sent", 32'(last_c()), 32'h81);
    n = 0;
    while (rdy_c && n < 50) begin n++; @(negedge clk); end
    chk("ref_idle_gap", n, 10);
    wait_rdy(2);
    chk("ref_81_resent", 32'(last_c()), 32'h81);
    chk("ref_count", q_c.size(), 3);
    repeat (9) @(negedge clk);
    seg_c = 8'h5A; vld_c = 1'b1;
    @(negedge clk);
    vld_c = 1'b0;
    chk("ref_valid_wins_busy", 32'(bsy_c), 1);
    wait_rdy(2);
    chk("ref_valid_wins_val", 32'(last_c()), 32'h5A);
    chk("ref_valid_wins_cnt", q_c.size(), 4);
    // DIV=1 frame of A5
    seg_a = 8'hA5; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    chk("a5_oe_before", 32'(oen_a), 1);
    n = 0;
    while (!rdy_a && n < 200) begin n++; @(negedge clk); end
    chk("a5_ready_low", n, 17);
    chk("a5_pattern", 32'(last_a()), 32'hA5);
    chk("a5_latches", q_a.size(), 1);
    chk("a5_rises", nrise_a, 8);
    chk("a5_oe_after", 32'(oen_a), 0);
    chk("a5_latch_low", 32'(lat_a), 0);
    // DIV=4 inverted frame of 3F
    seg_b = 8'h3F; vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    n = 0; run = 0; hi = 0; bad = 0; prev = 1'b0;
    while (!rdy_b && n < 500) begin
      n++;
      if (sck_b) hi++;
      if (sck_b === prev) run++;
      else begin
        if (run != 4) bad++;
        prev = sck_b;
        run = 1;
      end
      @(negedge clk);
    end
    chk("inv_frame_len", n, 68);
    chk("inv_phase_len", bad, 0);
    chk("inv_high_cycles", hi, 32);
    chk("inv_pattern", 32'(q_b.size() > 0 ? q_b[$] : 8'hxx), 32'hC0);
    chk("inv_oe", 32'(oen_b), 0);
    // mid-frame change with valid held: old frame completes, new one follows after one idle cycle
    seg_a = 8'h12; vld_a = 1'b1;
    repeat (3) @(negedge clk);
    seg_a = 8'h34;
    wait_rdy(0);
    chk("hold_old_pattern", 32'(last_a()), 32'h12);
    @(negedge clk);
    chk("hold_one_idle", 32'(rdy_a), 0);
    vld_a = 1'b0;
    wait_rdy(0);
    chk("hold_new_pattern", 32'(last_a()), 32'h34);
    chk("hold_count", q_a.size(), 3);
    // reset while bit 3 is being clocked
    seg_a = 8'hFF; vld_a = 1'b1;
    base = nrise_a;
    @(negedge clk);
    vld_a = 1'b0;
    n = 0;
    while (!(sck_a && nrise_a - base == 5) && n < 100) begin n++; @(negedge clk); end
    chk("abort_at_bit3", 32'(sck_a), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_sclk", 32'(sck_a), 0);
    chk("abort_latch", 32'(lat_a), 0);
    chk("abort_oe_n", 32'(oen_a), 1);
    chk("abort_ready", 32'(rdy_a), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_idle_ready", 32'(rdy_a), 1);
    chk("abort_idle_sclk", 32'(sck_a), 0);
    chk("abort_no_latch", q_a.size(), 3);
    // snake patterns with random gaps
    for (int i = 0; i < 3; i++) begin
      wait_rdy(0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      seg_a = pats[i]; vld_a = 1'b1;
      @(negedge clk);
      vld_a = 1'b0;
    end
    wait_rdy(0);
    chk("snake_count", q_a.size(), 6);
    for (int i = 0; i < 3; i++)
      chk($sformatf("snake_%0d", i), 32'(q_a.size() == 6 ? q_a[3+i] : 8'hxx), 32'(pats[i]));
    chk("snake_oe", 32'(oen_a), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
